tm1638_key_scan: RTL and testbench

Key-input front end for the TM1638 LED&KEY board. On each `start` request it runs one TM1638 read transaction on the shared CLK/STB/DIO lines: it sends command 0x42, then clocks in the 4 key-scan bytes. It decodes the 8 push buttons S1..S8 into a registered key vector plus one-cycle press pulses. It sits upstream of the up/down counter, supplying button events in place of slide switches, and shares the TM1638 bus with the display driver. Bus arbitration is handled at top level via `start`/`busy`.

---
 rtl/tm1638_key_scan.sv | 198 +++++++++++++++++++
 tb/tb_tm1638_key_scan.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tm1638_key_scan.sv
// rtl/tm1638_key_scan.sv - TM1638 key-scan reader: sends CMD_READ, clocks in 4 key bytes, decodes S1..S8
// Optional feature macro: TM1638_KEY_DEBOUNCE_EN (keys only follow two equal consecutive scans)
`timescale 1ns/1ps
module tm1638_key_scan #(
    parameter int          WAIT_CYC = 2,
    parameter logic [7:0]  CMD_READ = 8'h42
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    output logic       tm_clk,
    output logic       tm_stb,
    output logic       dio_out,
    output logic       dio_oe,
    input  logic       dio_in,
    output logic [7:0] keys,
    output logic [7:0] key_press,
    output logic       key_valid
);

    localparam int WAIT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam int CNT_W  = (WAIT_W > 6) ? WAIT_W : 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_CMD,
        S_WAIT,
        S_READ,
        S_END
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        shift_q, shift_d;
    logic [7:0]         keys_q, keys_d;
    logic [7:0]         press_q, press_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               tm_clk_q, tm_clk_d;
    logic               tm_stb_q, tm_stb_d;
    logic               dout_q, dout_d;
    logic               oe_q, oe_d;
    logic [7:0]         raw;
    logic [7:0]         keys_new;

    // Each key byte carries one button in bit 0 and another in bit 4
    assign raw = {shift_q[28], shift_q[20], shift_q[12], shift_q[4],
                  shift_q[24], shift_q[16], shift_q[8],  shift_q[0]};

`ifdef TM1638_KEY_DEBOUNCE_EN
    logic [7:0] prev_raw_q, prev_raw_d;

    assign keys_new = (raw == prev_raw_q) ? raw : keys_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_raw_q <= '0;
        end else begin
            prev_raw_q <= prev_raw_d;
        end
    end

    always_comb begin
        prev_raw_d = prev_raw_q;
        if (state_q == S_READ && cnt_q == CNT_W'(63)) begin
            prev_raw_d = raw;
        end
    end
`else
    assign keys_new = raw;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        keys_d   = keys_q;
        press_d  = '0;
        valid_d  = 1'b0;
        tm_clk_d = tm_clk_q;
        tm_stb_d = tm_stb_q;
        dout_d   = dout_q;
        oe_d     = oe_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_SETUP;
                    cnt_d    = '0;
                    tm_stb_d = 1'b0;
                    tm_clk_d = 1'b1;
                    oe_d     = 1'b1;
                    dout_d   = CMD_READ[0];
                end
            end
            S_SETUP: begin
                state_d  = S_CMD;
                cnt_d    = '0;
                tm_clk_d = 1'b0;
                dout_d   = CMD_READ[0];
            end
            S_CMD: begin
                if (cnt_q == CNT_W'(15)) begin
                    state_d  = S_WAIT;
                    cnt_d    = '0;
                    tm_clk_d = 1'b1;
                    oe_d     = 1'b0;
                    dout_d   = 1'b1;
                end else begin
                    cnt_d    = cnt_q + CNT_W'(1);
                    tm_clk_d = cnt_d[0];
                    // Bit only advances on the falling phase, so DIO is stable while CLK is high
                    dout_d   = CMD_READ[cnt_d[3:1]];
                end
            end
            S_WAIT: begin
                if (cnt_q == CNT_W'(WAIT_CYC - 1)) begin
                    state_d  = S_READ;
                    cnt_d    = '0;
                    tm_clk_d = 1'b0;
                end else begin
                    cnt_d    = cnt_q + CNT_W'(1);
                end
            end
            S_READ: begin
                // Sample on the edge that raises CLK; the chip shifts out on the falling edge
                if (!cnt_q[0]) begin
                    shift_d = {dio_in, shift_q[31:1]};
                end
                if (cnt_q == CNT_W'(63)) begin
                    state_d  = S_END;
                    cnt_d    = '0;
                    tm_stb_d = 1'b1;
                    tm_clk_d = 1'b1;
                    keys_d   = keys_new;
                    press_d  = keys_new & ~keys_q;
                    valid_d  = 1'b1;
                end else begin
                    cnt_d    = cnt_q + CNT_W'(1);
                    tm_clk_d = cnt_d[0];
                end
            end
            S_END: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d  = S_IDLE;
                cnt_d    = '0;
                tm_stb_d = 1'b1;
                tm_clk_d = 1'b1;
                oe_d     = 1'b0;
                dout_d   = 1'b1;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            shift_q  <= '0;
            keys_q   <= '0;
            press_q  <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            tm_clk_q <= 1'b1;
            tm_stb_q <= 1'b1;
            dout_q   <= 1'b1;
            oe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            keys_q   <= keys_d;
            press_q  <= press_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            tm_clk_q <= tm_clk_d;
            tm_stb_q <= tm_stb_d;
            dout_q   <= dout_d;
            oe_q     <= oe_d;
        end
    end

    assign busy      = busy_q;
    assign tm_clk    = tm_clk_q;
    assign tm_stb    = tm_stb_q;
    assign dio_out   = dout_q;
    assign dio_oe    = oe_q;
    assign keys      = keys_q;
    assign key_press = press_q;
    assign key_valid = valid_q;

endmodule

// File: tb/tb_tm1638_key_scan.sv
// tb/tb_tm1638_key_scan.sv - directed self-checking bench for tm1638_key_scan
`timescale 1ns/1ps
module tb_tm1638_key_scan;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       dio_in = 1'b1;
    logic       busy, tm_clk, tm_stb, dio_out, dio_oe, key_valid;
    logic [7:0] keys, key_press;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] scan_bytes = '0;
    int          rd_idx = 0;
    logic [7:0]  cmd_cap = '0;
    int          cmd_bits = 0;
    logic        p_clk = 1'b1;
    logic        p_stb = 1'b1;
    logic [7:0]  m_keys = '0;
`ifdef TM1638_KEY_DEBOUNCE_EN
    logic [7:0]  m_prev = '0;
`endif

    int pulses, prev_pulse, stb_run, min_run, vc, falls;
    logic seen_low;

    tm1638_key_scan #(.WAIT_CYC(2), .CMD_READ(8'h42)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .tm_clk    (tm_clk),
        .tm_stb    (tm_stb),
        .dio_out   (dio_out),
        .dio_oe    (dio_oe),
        .dio_in    (dio_in),
        .keys      (keys),
        .key_press (key_press),
        .key_valid (key_valid)
    );

    always #5 clk = ~clk;

    // TM1638 model: shifts key bits out on CLK falls, records command bits on CLK rises
    always @(negedge clk) begin
        if (p_stb && !tm_stb) begin
            rd_idx   = 0;
            cmd_bits = 0;
            cmd_cap  = '0;
        end
        if (!tm_stb && p_clk && !tm_clk && !dio_oe && rd_idx < 32) begin
            dio_in = scan_bytes[rd_idx];
            rd_idx++;
        end
        if (!tm_stb && !p_clk && tm_clk && dio_oe) begin
            cmd_cap = {dio_out, cmd_cap[7:1]};
            cmd_bits++;
        end
        p_clk = tm_clk;
        p_stb = tm_stb;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_scan(input logic [7:0] raw, output logic [7:0] exp_keys,
                              output logic [7:0] exp_press);
        logic [7:0] nk;
`ifdef TM1638_KEY_DEBOUNCE_EN
        nk     = (raw == m_prev) ? raw : m_keys;
        m_prev = raw;
`else
        nk = raw;
`endif
        exp_press = nk & ~m_keys;
        m_keys    = nk;
        exp_keys  = nk;
    endtask

    task automatic run_scan(input string tag, input logic [31:0] bytes, input logic [7:0] raw);
        logic [7:0] ek, ep;
        int lat;
        scan_bytes = bytes;
        model_scan(raw, ek, ep);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        check({tag, " busy rise"}, busy, 1);
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (key_valid) begin
                lat = n;
                break;
            end
        end
        check({tag, " latency"}, lat, 83);
        check({tag, " cmd byte"}, cmd_cap, 8'h42);
        check({tag, " cmd bits"}, cmd_bits, 8);
        check({tag, " keys"}, keys, ek);
        check({tag, " press"}, key_press, ep);
        @(posedge clk);
        #1;
        check({tag, " valid drop"}, key_valid, 0);
        check({tag, " press drop"}, key_press, 0);
        check({tag, " busy fall"}, busy, 0);
    endtask

    initial begin
        logic [7:0] ek, ep;

        repeat (3) @(posedge clk);
        #1;
        check("rst tm_stb", tm_stb, 1);
        check("rst tm_clk", tm_clk, 1);
        check("rst dio_oe", dio_oe, 0);
        check("rst dio_out", dio_out, 1);
        check("rst busy", busy, 0);
        check("rst keys", keys, 0);
        check("rst press", key_press, 0);
        check("rst valid", key_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_scan("s1", 32'h00100001, 8'h41);
        run_scan("s2", 32'h00100001, 8'h41);
        run_scan("s3", 32'hEEEEEEEE, 8'h00);
        run_scan("s4", 32'h11111111, 8'hFF);
        run_scan("s5", 32'h11111111, 8'hFF);
        run_scan("s6", 32'h01000110, 8'h1A);

        // start held high: back-to-back scans
        pulses = 0; prev_pulse = -1; stb_run = 0; min_run = 999; seen_low = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            #1;
            if (key_valid) begin
                pulses++;
                if (prev_pulse >= 0) check("held spacing", c - prev_pulse, 85);
                prev_pulse = c;
            end
            if (tm_stb) begin
                stb_run++;
            end else begin
                if (seen_low && stb_run > 0 && stb_run < min_run) min_run = stb_run;
                seen_low = 1'b1;
                stb_run  = 0;
            end
        end
        @(negedge clk);
        start = 1'b0;
        check("held pulses", pulses, 3);
        check("held stb gap", (min_run >= 2 && min_run < 999), 1);
        for (int n = 0; n < 200; n++) begin
            @(posedge clk);
            #1;
            if (!busy) break;
        end
        check("held idle", busy, 0);
        for (int k = 0; k < 4; k++) model_scan(8'h1A, ek, ep);
        check("held keys", keys, m_keys);

        // reset in the middle of READ
        scan_bytes = 32'h00000010;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (59) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort tm_stb", tm_stb, 1);
        check("abort tm_clk", tm_clk, 1);
        check("abort dio_oe", dio_oe, 0);
        check("abort dio_out", dio_out, 1);
        check("abort busy", busy, 0);
        check("abort keys", keys, 0);
        check("abort valid", key_valid, 0);
        m_keys = '0;
`ifdef TM1638_KEY_DEBOUNCE_EN
        m_prev = '0;
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        vc = 0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            #1;
            if (key_valid) vc++;
        end
        check("abort no valid", vc, 0);
        run_scan("post rst", 32'h00000010, 8'h10);

        // start re-pulsed during CMD is ignored
        scan_bytes = 32'h00001000;
        model_scan(8'h20, ek, ep);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vc = 0; falls = 0; p_stb_local_init();
        for (int n = 0; n < 250; n++) begin
            @(posedge clk);
            #1;
            if (key_valid) vc++;
            if (!tm_stb && seen_low) falls++;
            seen_low = tm_stb;
        end
        check("cmd start pulses", vc, 1);
        check("cmd start extra txn", falls, 0);
        check("cmd start keys", keys, ek);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic p_stb_local_init();
        seen_low = 1'b0;
    endtask

endmodule
